// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit write engine: one byte per req/ack handshake with RS/E/DB timing.
// Define LCD_INIT_EN to add the power-on wait and internal init sequence.
module lcd_hd44780_driver #(
    parameter int unsigned SETUP_CYCLES     = 2,
    parameter int unsigned PULSE_CYCLES     = 12,
    parameter int unsigned HOLD_CYCLES      = 2,
    parameter int unsigned EXEC_CYCLES      = 2000,
    parameter int unsigned LONG_EXEC_CYCLES = 80000,
    parameter int unsigned POWERON_CYCLES   = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_is_cmd,
    input  logic       data_req,
    output logic       data_ack,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam int unsigned MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_B = (HOLD_CYCLES > EXEC_CYCLES) ? HOLD_CYCLES : EXEC_CYCLES;
    localparam int unsigned MAX_C = (LONG_EXEC_CYCLES > POWERON_CYCLES) ? LONG_EXEC_CYCLES : POWERON_CYCLES;
    localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYCLES = (MAX_C > MAX_D) ? MAX_C : MAX_D;
    localparam int unsigned TW = $clog2(MAX_CYCLES);

    // Timer is loaded with N-1 and the transition fires when it reads zero.
    localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_HOLD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] T_EXEC  = TW'(EXEC_CYCLES - 1);
    localparam logic [TW-1:0] T_LONG  = TW'(LONG_EXEC_CYCLES - 1);

`ifdef LCD_INIT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_ACK, S_PWR_WAIT
    } state_t;
    localparam state_t RESET_STATE = S_PWR_WAIT;
    localparam logic [TW-1:0] T_PWR = TW'(POWERON_CYCLES - 1);

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h0C;
            3'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    logic [2:0] init_idx, init_idx_nxt;
    logic       init_busy;
    assign init_busy = (init_idx != 3'd4);
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_ACK
    } state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          e_nxt, rs_nxt, ack_nxt;
    logic [7:0]    db_nxt;
    logic          timer_zero, long_cmd;

    assign lcd_rw     = 1'b0;
    assign timer_zero = (timer == '0);
    assign long_cmd   = !lcd_rs && (lcd_db == 8'h01 || lcd_db == 8'h02 || lcd_db == 8'h03);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET_STATE;
            timer    <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_db   <= '0;
            data_ack <= 1'b0;
`ifdef LCD_INIT_EN
            init_idx <= '0;
`endif
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            lcd_e    <= e_nxt;
            lcd_rs   <= rs_nxt;
            lcd_db   <= db_nxt;
            data_ack <= ack_nxt;
`ifdef LCD_INIT_EN
            init_idx <= init_idx_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        e_nxt     = lcd_e;
        rs_nxt    = lcd_rs;
        db_nxt    = lcd_db;
        ack_nxt   = data_ack;
`ifdef LCD_INIT_EN
        init_idx_nxt = init_idx;
`endif
        case (state)
            S_IDLE: begin
`ifdef LCD_INIT_EN
                if (init_busy) begin
                    db_nxt    = init_byte(init_idx);
                    rs_nxt    = 1'b0;
                    timer_nxt = T_SETUP;
                    state_nxt = S_SETUP;
                end else
`endif
                if (data_req) begin
                    db_nxt    = data;
                    rs_nxt    = ~data_is_cmd;
                    timer_nxt = T_SETUP;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (timer_zero) begin
                    e_nxt     = 1'b1;
                    timer_nxt = T_PULSE;
                    state_nxt = S_PULSE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_PULSE: begin
                if (timer_zero) begin
                    e_nxt     = 1'b0;
                    timer_nxt = T_HOLD;
                    state_nxt = S_HOLD;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_HOLD: begin
                if (timer_zero) begin
                    timer_nxt = long_cmd ? T_LONG : T_EXEC;
                    state_nxt = S_EXEC;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_EXEC: begin
                if (timer_zero) begin
`ifdef LCD_INIT_EN
                    // Init-sequence bytes return to IDLE silently.
                    if (init_busy) begin
                        init_idx_nxt = init_idx + 3'd1;
                        state_nxt    = S_IDLE;
                    end else begin
                        ack_nxt   = 1'b1;
                        state_nxt = S_ACK;
                    end
`else
                    ack_nxt   = 1'b1;
                    state_nxt = S_ACK;
`endif
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_ACK: begin
                if (!data_req) begin
                    ack_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
`ifdef LCD_INIT_EN
            // Power-on wait counts up from the cleared reset value.
            S_PWR_WAIT: begin
                if (timer == T_PWR) begin
                    timer_nxt = '0;
                    state_nxt = S_IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
`endif
            default: begin
                e_nxt     = 1'b0;
                ack_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed bench for lcd_hd44780_driver: E-strobe scoreboard, latency and handshake checks.
// With LCD_INIT_EN defined it exercises the power-on init sequence instead.
module tb_lcd_hd44780_driver;

    localparam int SETUP    = 2;
    localparam int PULSE    = 12;
    localparam int HOLD     = 2;
    localparam int EXEC     = 2000;
    localparam int LONG     = 8000;
    localparam int PWR      = 5000;
    localparam int LAT      = 1 + SETUP + PULSE + HOLD + EXEC;
    localparam int LAT_LONG = 1 + SETUP + PULSE + HOLD + LONG;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       data_is_cmd = 1'b0;
    logic       data_req = 1'b0;
    logic       data_ack, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;

    int checks   = 0;
    int failures = 0;
    int e_pulses = 0;
    logic [8:0] sb_q[$];

    lcd_hd44780_driver #(
        .SETUP_CYCLES(SETUP),
        .PULSE_CYCLES(PULSE),
        .HOLD_CYCLES(HOLD),
        .EXEC_CYCLES(EXEC),
        .LONG_EXEC_CYCLES(LONG),
        .POWERON_CYCLES(PWR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .data_is_cmd(data_is_cmd),
        .data_req(data_req),
        .data_ack(data_ack),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_e(lcd_e),
        .lcd_db(lcd_db)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each E rising edge pops the expected {RS,DB}; each falling edge checks the width.
    logic e_prev = 1'b0;
    int   hi_cnt = 0;
    always @(negedge clk) begin
        logic [8:0] exp_b;
        if (rst) begin
            e_prev = 1'b0;
            hi_cnt = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                e_pulses++;
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("sb_rs_db", 32'({lcd_rs, lcd_db}), 32'(exp_b));
                end
            end
            if (lcd_e) hi_cnt++;
            else if (e_prev) begin
                check("e_width", 32'(hi_cnt), 32'(PULSE));
                hi_cnt = 0;
            end
            e_prev = lcd_e;
        end
    end

    task automatic do_write(input logic [7:0] d, input logic c, input int exp_lat,
                            input string tag, input int poke_at);
        int n, rise, last, p0;
        logic seen;
        p0 = e_pulses;
        sb_q.push_back({~c, d});
        @(posedge clk); #1;
        data = d; data_is_cmd = c; data_req = 1'b1;
        n = 0; rise = 0; last = 0; seen = 1'b0;
        while (!seen && n < exp_lat + 200) begin
            @(posedge clk); #1;
            n++;
            if (lcd_e) begin
                if (rise == 0) rise = n;
                last = n;
            end
            if (poke_at != 0 && n == poke_at) begin
                data = 8'hFF; data_is_cmd = ~c;
            end
            if (poke_at != 0 && n == poke_at + 1) data_req = 1'b0;
            if (poke_at != 0 && n == poke_at + 2) data_req = 1'b1;
            seen = data_ack;
        end
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_e_rise"}, 32'(rise), 32'(SETUP + 1));
        check({tag, "_e_len"}, 32'(last - rise + 1), 32'(PULSE));
        check({tag, "_rs_db"}, 32'({lcd_rs, lcd_db}), 32'({~c, d}));
        check({tag, "_pulses"}, 32'(e_pulses - p0), 32'd1);
    endtask

    task automatic release_req(input string tag);
        data_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ack_drop"}, 32'(data_ack), 32'd0);
    endtask

    initial begin
        int p0, cnt;
`ifdef LCD_INIT_EN
        int n;
        data = 8'h41; data_is_cmd = 1'b0; data_req = 1'b1;
        sb_q.push_back(9'h038);
        sb_q.push_back(9'h00C);
        sb_q.push_back(9'h001);
        sb_q.push_back(9'h006);
        sb_q.push_back(9'h141);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        while (!data_ack && n < PWR + LAT_LONG + 5 * LAT + 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("init_ack_seen", 32'(data_ack), 32'd1);
        check("init_pulses", 32'(e_pulses), 32'd5);
        check("init_rs_db", 32'({lcd_rs, lcd_db}), 32'h141);
        check("init_sb_empty", 32'(sb_q.size()), 32'd0);
        release_req("init");
        p0 = e_pulses;
        repeat (LAT + 50) @(posedge clk);
        #1;
        check("init_no_extra", 32'(e_pulses - p0), 32'd0);
`else
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(data_ack), 32'd0);
        check("rst_e", 32'(lcd_e), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        check("rst_db", 32'(lcd_db), 32'd0);
        rst = 1'b0;

        // Reset asserted while E is high abandons the byte.
        sb_q.push_back(9'h155);
        @(posedge clk); #1;
        data = 8'h55; data_is_cmd = 1'b0; data_req = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_e_high", 32'(lcd_e), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_e", 32'(lcd_e), 32'd0);
        check("abort_ack", 32'(data_ack), 32'd0);
        check("abort_rs_db", 32'({lcd_rs, lcd_db}), 32'd0);
        check("abort_rw", 32'(lcd_rw), 32'd0);
        data_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        p0 = e_pulses; cnt = 0;
        repeat (LAT + 50) begin
            @(posedge clk); #1;
            if (data_ack) cnt++;
        end
        check("abort_no_ack", 32'(cnt), 32'd0);
        check("abort_no_pulse", 32'(e_pulses - p0), 32'd0);

        do_write(8'h41, 1'b0, LAT, "data41", 0);
        release_req("data41");
        do_write(8'h01, 1'b1, LAT_LONG, "clr_cmd", 0);
        release_req("clr_cmd");
        do_write(8'h01, 1'b0, LAT, "data01", 0);
        release_req("data01");
        do_write(8'h03, 1'b1, LAT_LONG, "home_cmd", 0);
        release_req("home_cmd");
        do_write(8'h04, 1'b1, LAT, "cmd04", 0);
        release_req("cmd04");

        // Request held long after ack.
        do_write(8'h41, 1'b0, LAT, "hold", 0);
        p0 = e_pulses; cnt = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (!data_ack) cnt++;
        end
        check("hold_ack_low", 32'(cnt), 32'd0);
        check("hold_no_pulse", 32'(e_pulses - p0), 32'd0);
        release_req("hold");

        // Input changes and a req blip mid-transfer are ignored.
        do_write(8'h41, 1'b0, LAT, "poke", 6);
        release_req("poke");

        p0 = e_pulses;
        do_write(8'h48, 1'b0, LAT, "b2b0", 0);
        release_req("b2b0");
        do_write(8'h80, 1'b1, LAT, "b2b1", 0);
        release_req("b2b1");
        do_write(8'hC5, 1'b0, LAT, "b2b2", 0);
        release_req("b2b2");
        check("b2b_pulses", 32'(e_pulses - p0), 32'd3);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
